// File: rtl/branch_predictor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_pkg
//  Description : Shared types and helpers for the BTB branch predictor.
//  Revision    : 1.0 - initial release
// ============================================================================
package branch_predictor_pkg;

    localparam int PC_W = 32;

    // Kind of table write performed by a resolving instruction
    typedef enum logic [1:0] {
        UPD_NONE  = 2'd0,
        UPD_HIT   = 2'd1,
        UPD_ALLOC = 2'd2
    } btb_upd_e;

    // Sequential fall-through address; wraps modulo 2^32
    function automatic logic [PC_W-1:0] pc_inc4(input logic [PC_W-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage : branch_predictor_pkg
`default_nettype wire

// File: rtl/branch_predictor_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Combinational saturating up/down step of a direction counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr,
    input  logic             inc,
    output logic [CTR_W-1:0] nxt
);

    localparam logic [CTR_W-1:0] c_ctr_max = {CTR_W{1'b1}};

    // Step toward taken on inc, toward not-taken otherwise, clamping at the ends
    always_comb begin
        nxt = ctr;
        if (inc) begin
            if (ctr != c_ctr_max) nxt = ctr + 1'b1;
        end else begin
            if (ctr != '0) nxt = ctr - 1'b1;
        end
    end

endmodule : sat_counter
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Direct-mapped branch target buffer with saturating direction
//                counters; zero-latency IF lookup, EX/MEM update and
//                misprediction / recovery-PC generation.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int PERF_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [31:0]       lk_pc,
    output logic              lk_hit,
    output logic              lk_taken,
    output logic [31:0]       lk_npc,
    input  logic              rs_en,
    input  logic [31:0]       rs_pc,
    input  logic              rs_cond,
    input  logic              rs_taken,
    input  logic [31:0]       rs_target,
    input  logic              rs_pred_taken,
    input  logic [31:0]       rs_pred_npc,
    output logic              mispredict,
    output logic [31:0]       fix_pc,
    output logic [PERF_W-1:0] perf_branches,
    output logic [PERF_W-1:0] perf_miss
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    // Weakly not-taken is the reset state, weakly taken the allocation state
    // for conditional branches; jumps live at all ones.
    localparam logic [CTR_W-1:0] c_ctr_wnt = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CTR_W-1:0] c_ctr_wt  = {1'b1, {(CTR_W-1){1'b0}}};
    localparam logic [CTR_W-1:0] c_ctr_max = {CTR_W{1'b1}};
    localparam logic [PERF_W-1:0] c_perf_max = {PERF_W{1'b1}};

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic [CTR_W-1:0] ctr;
    } btb_entry_t;

    localparam btb_entry_t c_reset_entry = '{
        valid:  1'b0,
        tag:    '0,
        target: '0,
        ctr:    c_ctr_wnt
    };

    btb_entry_t r_table [ENTRIES];

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    btb_entry_t       w_lk_e;

    logic [IDX_W-1:0] w_rs_idx;
    logic [TAG_W-1:0] w_rs_tag;
    btb_entry_t       w_rs_e;
    logic             w_rs_hit;
    logic [CTR_W-1:0] w_ctr_step;
    btb_entry_t       w_new;
    btb_upd_e         w_upd;
    logic [31:0]      w_actual_npc;

    // rs_pred_taken travels with the instruction for debug only
    logic w_unused;
    assign w_unused = rs_pred_taken;

    // ---------------- IF-stage lookup (read-before-write, no bypass) -------
    assign w_lk_idx = lk_pc[IDX_W+1:2];
    assign w_lk_tag = lk_pc[31:IDX_W+2];
    assign w_lk_e   = r_table[w_lk_idx];
    assign lk_hit   = w_lk_e.valid && (w_lk_e.tag == w_lk_tag);
    assign lk_taken = lk_hit && w_lk_e.ctr[CTR_W-1];
    assign lk_npc   = lk_taken ? w_lk_e.target : pc_inc4(lk_pc);

    // ---------------- EX/MEM resolution ------------------------------------
    assign w_rs_idx = rs_pc[IDX_W+1:2];
    assign w_rs_tag = rs_pc[31:IDX_W+2];
    assign w_rs_e   = r_table[w_rs_idx];
    assign w_rs_hit = w_rs_e.valid && (w_rs_e.tag == w_rs_tag);

    // Mispredict compares full next PC, so a right direction with a stale
    // target (register-indirect jump) is still caught.
    assign w_actual_npc = rs_taken ? rs_target : pc_inc4(rs_pc);
    assign mispredict   = rs_en && (w_actual_npc != rs_pred_npc);
    assign fix_pc       = w_actual_npc;

    sat_counter #(
        .CTR_W (CTR_W)
    ) u_sat_counter (
        .ctr (w_rs_e.ctr),
        .inc (rs_taken),
        .nxt (w_ctr_step)
    );

    // Decide whether the resolving instruction trains a hit, allocates, or is dropped
    always_comb begin
        w_upd = UPD_NONE;
        w_new = w_rs_e;
        if (rs_en) begin
            if (w_rs_hit) begin
                w_upd     = UPD_HIT;
                w_new.ctr = rs_cond ? w_ctr_step : c_ctr_max;
                if (rs_taken) w_new.target = rs_target;
            end else if (rs_taken) begin
                w_upd        = UPD_ALLOC;
                w_new.valid  = 1'b1;
                w_new.tag    = w_rs_tag;
                w_new.target = rs_target;
                w_new.ctr    = rs_cond ? c_ctr_wt : c_ctr_max;
            end
        end
    end

    // Table storage: clear on reset, single write port from the resolve stage
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) r_table[i] <= c_reset_entry;
        end else if (w_upd != UPD_NONE) begin
            r_table[w_rs_idx] <= w_new;
        end
    end

    // Saturating performance counters for resolved transfers and mispredicts
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perf_branches <= '0;
            perf_miss     <= '0;
        end else begin
            if (rs_en && (perf_branches != c_perf_max))
                perf_branches <= perf_branches + 1'b1;
            if (mispredict && (perf_miss != c_perf_max))
                perf_miss <= perf_miss + 1'b1;
        end
    end

endmodule : branch_predictor
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor
//  Description : Directed self-checking bench for branch_predictor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    localparam int PERF_W = 4;

    logic              CLK;
    logic              RST;
    logic [31:0]       lk_pc;
    logic              lk_hit;
    logic              lk_taken;
    logic [31:0]       lk_npc;
    logic              rs_en;
    logic [31:0]       rs_pc;
    logic              rs_cond;
    logic              rs_taken;
    logic [31:0]       rs_target;
    logic              rs_pred_taken;
    logic [31:0]       rs_pred_npc;
    logic              mispredict;
    logic [31:0]       fix_pc;
    logic [PERF_W-1:0] perf_branches;
    logic [PERF_W-1:0] perf_miss;

    int checks   = 0;
    int failures = 0;

    branch_predictor #(
        .ENTRIES (16),
        .CTR_W   (2),
        .PERF_W  (PERF_W)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .lk_pc         (lk_pc),
        .lk_hit        (lk_hit),
        .lk_taken      (lk_taken),
        .lk_npc        (lk_npc),
        .rs_en         (rs_en),
        .rs_pc         (rs_pc),
        .rs_cond       (rs_cond),
        .rs_taken      (rs_taken),
        .rs_target     (rs_target),
        .rs_pred_taken (rs_pred_taken),
        .rs_pred_npc   (rs_pred_npc),
        .mispredict    (mispredict),
        .fix_pc        (fix_pc),
        .perf_branches (perf_branches),
        .perf_miss     (perf_miss)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Present a resolving instruction (applied mid-cycle, settles after #1)
    task automatic drive_rs(input logic [31:0] pc, input logic cond, input logic taken,
                            input logic [31:0] target, input logic [31:0] pred_npc);
        rs_en         = 1'b1;
        rs_pc         = pc;
        rs_cond       = cond;
        rs_taken      = taken;
        rs_target     = target;
        rs_pred_npc   = pred_npc;
        rs_pred_taken = (pred_npc != pc + 32'd4);
        #1;
    endtask

    // Commit on the next rising edge, then return to mid-cycle with rs idle
    task automatic tick();
        @(posedge CLK);
        #1;
        rs_en = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; rs_en = 1'b0; rs_pc = '0; rs_cond = 1'b0; rs_taken = 1'b0;
        rs_target = '0; rs_pred_taken = 1'b0; rs_pred_npc = '0; lk_pc = 32'h40;
        repeat (2) @(posedge CLK);
        #1; RST = 1'b0; #1;
        checks++; if (lk_hit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%0b exp=0", lk_hit); end
        checks++; if (lk_taken !== 1'b0) begin failures++; $display("FAIL reset_taken got=%0b exp=0", lk_taken); end
        checks++; if (lk_npc !== 32'h44) begin failures++; $display("FAIL reset_npc got=%h exp=00000044", lk_npc); end
        checks++; if (perf_branches !== 4'd0 || perf_miss !== 4'd0) begin failures++;
            $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_branches, perf_miss); end
        lk_pc = 32'hFFFF_FFFC; #1;
        checks++; if (lk_npc !== 32'h0) begin failures++; $display("FAIL npc_wrap got=%h exp=00000000", lk_npc); end
    endtask

    task automatic test_allocate();
        lk_pc = 32'h40;
        drive_rs(32'h40, 1'b1, 1'b1, 32'h80, 32'h44);
        checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL alloc_mis got=%0b exp=1", mispredict); end
        checks++; if (fix_pc !== 32'h80) begin failures++; $display("FAIL alloc_fix got=%h exp=00000080", fix_pc); end
        tick();
        checks++; if (perf_miss !== 4'd1) begin failures++; $display("FAIL alloc_perf_miss got=%0d exp=1", perf_miss); end
        checks++; if (lk_hit !== 1'b1 || lk_taken !== 1'b1 || lk_npc !== 32'h80) begin failures++;
            $display("FAIL alloc_lookup got=%0b/%0b/%h exp=1/1/00000080", lk_hit, lk_taken, lk_npc); end
    endtask

    task automatic test_counter();
        lk_pc = 32'h40;
        // ctr 2 -> 1
        drive_rs(32'h40, 1'b1, 1'b0, 32'h80, 32'h80);
        checks++; if (mispredict !== 1'b1 || fix_pc !== 32'h44) begin failures++;
            $display("FAIL nt1_mis got=%0b/%h exp=1/00000044", mispredict, fix_pc); end
        tick();
        checks++; if (lk_hit !== 1'b1 || lk_taken !== 1'b0 || lk_npc !== 32'h44) begin failures++;
            $display("FAIL nt1_lookup got=%0b/%0b/%h exp=1/0/00000044", lk_hit, lk_taken, lk_npc); end
        // ctr 1 -> 0, predicted correctly
        drive_rs(32'h40, 1'b1, 1'b0, 32'h80, 32'h44);
        checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL nt2_mis got=%0b exp=0", mispredict); end
        tick();
        // ctr 0 -> 1: still not taken only if 0 saturated
        drive_rs(32'h40, 1'b1, 1'b1, 32'h80, 32'h44);
        tick();
        checks++; if (lk_taken !== 1'b0 || lk_npc !== 32'h44) begin failures++;
            $display("FAIL sat_zero got=%0b/%h exp=0/00000044", lk_taken, lk_npc); end
        // ctr 1 -> 2
        drive_rs(32'h40, 1'b1, 1'b1, 32'h80, 32'h44);
        tick();
        checks++; if (lk_taken !== 1'b1 || lk_npc !== 32'h80) begin failures++;
            $display("FAIL retrain got=%0b/%h exp=1/00000080", lk_taken, lk_npc); end
        checks++; if (perf_branches !== 4'd5 || perf_miss !== 4'd4) begin failures++;
            $display("FAIL counter_perf got=%0d/%0d exp=5/4", perf_branches, perf_miss); end
    endtask

    task automatic test_alias();
        drive_rs(32'h80, 1'b1, 1'b1, 32'h100, 32'h84);
        tick();
        lk_pc = 32'h40; #1;
        checks++; if (lk_hit !== 1'b0 || lk_npc !== 32'h44) begin failures++;
            $display("FAIL alias_evict got=%0b/%h exp=0/00000044", lk_hit, lk_npc); end
        lk_pc = 32'h80; #1;
        checks++; if (lk_hit !== 1'b1 || lk_npc !== 32'h100) begin failures++;
            $display("FAIL alias_new got=%0b/%h exp=1/00000100", lk_hit, lk_npc); end
    endtask

    task automatic test_jr();
        lk_pc = 32'h100;
        drive_rs(32'h100, 1'b0, 1'b1, 32'h200, 32'h104);
        tick();
        checks++; if (lk_hit !== 1'b1 || lk_taken !== 1'b1 || lk_npc !== 32'h200) begin failures++;
            $display("FAIL jr_alloc got=%0b/%0b/%h exp=1/1/00000200", lk_hit, lk_taken, lk_npc); end
        drive_rs(32'h100, 1'b0, 1'b1, 32'h300, 32'h200);
        checks++; if (mispredict !== 1'b1 || fix_pc !== 32'h300) begin failures++;
            $display("FAIL jr_target_mis got=%0b/%h exp=1/00000300", mispredict, fix_pc); end
        tick();
        checks++; if (lk_npc !== 32'h300) begin failures++; $display("FAIL jr_retarget got=%h exp=00000300", lk_npc); end
        drive_rs(32'h100, 1'b0, 1'b1, 32'h300, 32'h300);
        checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL jr_correct got=%0b exp=0", mispredict); end
        tick();
        checks++; if (perf_branches !== 4'd9 || perf_miss !== 4'd7) begin failures++;
            $display("FAIL jr_perf got=%0d/%0d exp=9/7", perf_branches, perf_miss); end
    endtask

    task automatic test_back_to_back();
        lk_pc = 32'h48;
        drive_rs(32'h48, 1'b1, 1'b1, 32'h400, 32'h4C);
        checks++; if (lk_hit !== 1'b0 || lk_npc !== 32'h4C) begin failures++;
            $display("FAIL rbw_old got=%0b/%h exp=0/0000004c", lk_hit, lk_npc); end
        tick();
        checks++; if (lk_hit !== 1'b1 || lk_npc !== 32'h400) begin failures++;
            $display("FAIL rbw_new got=%0b/%h exp=1/00000400", lk_hit, lk_npc); end
        // Reset asserted mid-cycle while an update is pending
        drive_rs(32'h48, 1'b1, 1'b1, 32'h500, 32'h400);
        RST = 1'b1; #1;
        checks++; if (lk_hit !== 1'b0 || lk_npc !== 32'h4C) begin failures++;
            $display("FAIL async_rst got=%0b/%h exp=0/0000004c", lk_hit, lk_npc); end
        checks++; if (perf_branches !== 4'd0 || perf_miss !== 4'd0) begin failures++;
            $display("FAIL async_rst_perf got=%0d/%0d exp=0/0", perf_branches, perf_miss); end
        checks++; if (mispredict !== 1'b1 || fix_pc !== 32'h500) begin failures++;
            $display("FAIL rst_mis_comb got=%0b/%h exp=1/00000500", mispredict, fix_pc); end
        @(posedge CLK); #1;
        checks++; if (lk_hit !== 1'b0) begin failures++; $display("FAIL rst_hold got=%0b exp=0", lk_hit); end
        rs_en = 1'b0; RST = 1'b0; #1;
        lk_pc = 32'h100; #1;
        checks++; if (lk_hit !== 1'b0) begin failures++; $display("FAIL rst_clear_all got=%0b exp=0", lk_hit); end
    endtask

    task automatic test_perf_sat();
        for (int i = 0; i < 17; i++) begin
            drive_rs(32'h200, 1'b1, 1'b0, 32'h0, 32'h0);
            tick();
        end
        checks++; if (perf_branches !== 4'hF || perf_miss !== 4'hF) begin failures++;
            $display("FAIL perf_sat got=%0d/%0d exp=15/15", perf_branches, perf_miss); end
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_counter();
        test_alias();
        test_jr();
        test_back_to_back();
        test_perf_sat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the bench always terminates
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_branch_predictor
`default_nettype wire
